// File: rtl/port_rx_frontend.sv
// Receive front end for one switch port. Strips preamble/SFD, checks that the
// downstream data FIFO can take a full-size frame before accepting it, writes the
// frame bytes into the data FIFO, and commits a length/status descriptor to the
// pointer FIFO once the frame ends. Keeps frame, drop and error statistics.
module port_rx_frontend #(
  parameter int unsigned MAX_LEN    = 1518,
  parameter int unsigned MIN_LEN    = 64,
  parameter int unsigned FIFO_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_d,
  output logic        data_fifo_wr,
  output logic [7:0]  data_fifo_din,
  input  logic [11:0] data_fifo_cnt,
  output logic        ptr_fifo_wr,
  output logic [15:0] ptr_fifo_din,
  input  logic        ptr_fifo_full,
  output logic [31:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPreamble = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StCommit   = 3'd3;
  localparam logic [2:0] StDrop     = 3'd4;

  localparam logic [7:0]  PreambleByte = 8'h55;
  localparam logic [7:0]  SfdByte      = 8'hD5;
  localparam logic [10:0] MaxLen       = 11'(MAX_LEN);
  localparam logic [10:0] MinLen       = 11'(MIN_LEN);
  localparam logic [12:0] Depth        = 13'(FIFO_DEPTH);

  logic [2:0]  state_q, state_d;
  logic [10:0] len_q, len_d;
  logic        rx_err_q, rx_err_d;
  logic        len_err_q, len_err_d;
  logic        data_wr_q, data_wr_d;
  logic [7:0]  data_din_q, data_din_d;
  logic        ptr_wr_q, ptr_wr_d;
  logic [15:0] ptr_din_q, ptr_din_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [12:0] free_space;
  logic        admit;
  logic        sfd_hit;
  logic        drop_inc;
  logic        err_inc;
  logic        len_short;

  // Admission: room for a worst-case frame in the data FIFO and a free descriptor slot.
  always_comb begin
    free_space = 13'd0;
    if (13'(data_fifo_cnt) < Depth) begin
      free_space = Depth - 13'(data_fifo_cnt);
    end
    admit = (free_space >= 13'(MAX_LEN)) && !ptr_fifo_full;
  end

  // Frame state machine, length/flag tracking and registered FIFO write strobes.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rx_err_d    = rx_err_q;
    len_err_d   = len_err_q;
    data_wr_d   = 1'b0;
    data_din_d  = data_din_q;
    ptr_wr_d    = 1'b0;
    ptr_din_d   = ptr_din_q;
    frame_cnt_d = frame_cnt_q;
    sfd_hit     = 1'b0;
    drop_inc    = 1'b0;
    err_inc     = 1'b0;
    len_short   = (len_q < MinLen);

    case (state_q)
      StIdle: begin
        if (rx_dv) begin
          if (rx_d == PreambleByte) begin
            state_d = StPreamble;
          end else if (rx_d == SfdByte) begin
            sfd_hit = 1'b1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!rx_dv) begin
          state_d = StIdle;
        end else if (rx_d == SfdByte) begin
          sfd_hit = 1'b1;
        end else if (rx_d != PreambleByte) begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (rx_dv) begin
          if (len_q < MaxLen) begin
            data_wr_d  = 1'b1;
            data_din_d = rx_d;
            len_d      = len_q + 11'd1;
          end else begin
            len_err_d = 1'b1;
          end
          if (rx_er) begin
            rx_err_d = 1'b1;
          end
        end else if (len_q == 11'd0) begin
          // Nothing was written, so there is nothing to describe.
          state_d = StIdle;
        end else begin
          state_d   = StCommit;
          len_err_d = len_err_q | len_short;
          ptr_wr_d  = 1'b1;
          ptr_din_d = {rx_err_q, len_err_q | len_short, 3'b000, len_q};
        end
      end
      StCommit: begin
        frame_cnt_d = frame_cnt_q + 32'd1;
        err_inc     = rx_err_q | len_err_q;
        if (rx_dv) begin
          // A new burst with no inter-frame gap cannot be aligned; discard it.
          state_d  = StDrop;
          drop_inc = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (!rx_dv) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (sfd_hit) begin
      if (admit) begin
        state_d   = StData;
        len_d     = 11'd0;
        rx_err_d  = 1'b0;
        len_err_d = 1'b0;
      end else begin
        state_d  = StDrop;
        drop_inc = 1'b1;
      end
    end

    drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    err_cnt_d  = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      len_q       <= 11'd0;
      rx_err_q    <= 1'b0;
      len_err_q   <= 1'b0;
      data_wr_q   <= 1'b0;
      data_din_q  <= 8'd0;
      ptr_wr_q    <= 1'b0;
      ptr_din_q   <= 16'd0;
      frame_cnt_q <= 32'd0;
      drop_cnt_q  <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rx_err_q    <= rx_err_d;
      len_err_q   <= len_err_d;
      data_wr_q   <= data_wr_d;
      data_din_q  <= data_din_d;
      ptr_wr_q    <= ptr_wr_d;
      ptr_din_q   <= ptr_din_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_fifo_wr  = data_wr_q;
  assign data_fifo_din = data_din_q;
  assign ptr_fifo_wr   = ptr_wr_q;
  assign ptr_fifo_din  = ptr_din_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_port_rx_frontend.sv
// Bench for port_rx_frontend: directed and random frames against a frame-level model.
module tb_port_rx_frontend;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rx_d = 8'd0;
  logic        data_fifo_wr;
  logic [7:0]  data_fifo_din;
  logic [11:0] data_fifo_cnt = 12'd0;
  logic        ptr_fifo_wr;
  logic [15:0] ptr_fifo_din;
  logic        ptr_fifo_full = 1'b0;
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  port_rx_frontend dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_dv        (rx_dv),
    .rx_er        (rx_er),
    .rx_d         (rx_d),
    .data_fifo_wr (data_fifo_wr),
    .data_fifo_din(data_fifo_din),
    .data_fifo_cnt(data_fifo_cnt),
    .ptr_fifo_wr  (ptr_fifo_wr),
    .ptr_fifo_din (ptr_fifo_din),
    .ptr_fifo_full(ptr_fifo_full),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed FIFO traffic.
  logic [7:0]  got_d[$];
  logic [15:0] got_p[$];
  int cyc = 0;
  int last_d_cyc = 0;
  int p_cyc = 0;
  int overlap = 0;

  always @(negedge clk) begin
    cyc++;
    if (data_fifo_wr) begin
      got_d.push_back(data_fifo_din);
      last_d_cyc = cyc;
    end
    if (ptr_fifo_wr) begin
      got_p.push_back(ptr_fifo_din);
      p_cyc = cyc;
      if (data_fifo_wr) overlap++;
    end
  end

  // Frame-level reference model.
  logic [7:0]  exp_d[$];
  logic [15:0] exp_p[$];
  int exp_frame = 0;
  int exp_drop  = 0;
  int exp_err   = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic compare_frame(input string tag);
    int n;
    check_eq({tag, "_nwr"}, got_d.size(), exp_d.size());
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_byte"}, {24'd0, got_d[i]}, {24'd0, exp_d[i]});
    check_eq({tag, "_nptr"}, got_p.size(), exp_p.size());
    if (got_p.size() == 1 && exp_p.size() == 1) begin
      check_eq({tag, "_desc"}, {16'd0, got_p[0]}, {16'd0, exp_p[0]});
      if (got_d.size() > 0) check_eq({tag, "_ptr_after_data"}, {31'd0, p_cyc > last_d_cyc}, 32'd1);
    end
    check_eq({tag, "_overlap"}, overlap, 0);
    check_eq({tag, "_frame_cnt"}, frame_cnt, exp_frame);
    check_eq({tag, "_drop_cnt"}, {16'd0, drop_cnt}, exp_drop);
    check_eq({tag, "_err_cnt"}, {16'd0, err_cnt}, exp_err);
    got_d.delete();
    got_p.delete();
    exp_d.delete();
    exp_p.delete();
  endtask

  // Drives one frame and predicts its outcome from the frame's description.
  task automatic send_frame(input int pre, input int n, input int er_pos, input int cnt,
                            input bit full, input bit seq, input bit tail);
    logic [7:0] b;
    bit admit, re, le;
    int written;
    admit   = ((4096 - cnt) >= 1518) && !full;
    re      = 1'b0;
    written = 0;
    @(negedge clk);
    data_fifo_cnt = 12'(cnt);
    ptr_fifo_full = full;
    for (int i = 0; i < pre; i++) begin
      rx_dv = 1'b1; rx_er = 1'b0; rx_d = 8'h55;
      @(negedge clk);
    end
    rx_dv = 1'b1; rx_er = 1'b0; rx_d = 8'hD5;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      rx_d = b;
      rx_er = (i == er_pos);
      @(negedge clk);
      if (admit) begin
        if (i < 1518) begin
          exp_d.push_back(b);
          written++;
        end
        if (i == er_pos) re = 1'b1;
      end
    end
    rx_dv = 1'b0; rx_er = 1'b0; rx_d = 8'h00;
    if (!admit) begin
      exp_drop = sat16(exp_drop + 1);
    end else if (n > 0) begin
      le = (n > 1518) || (n < 64);
      exp_p.push_back({re, le, 3'b000, 11'(written)});
      exp_frame++;
      if (re || le) exp_err = sat16(exp_err + 1);
      if (tail) exp_drop = sat16(exp_drop + 1);
    end
    if (tail) begin
      @(negedge clk);
      rx_dv = 1'b1; rx_d = 8'hAA;
      repeat (4) @(negedge clk);
      rx_dv = 1'b0; rx_d = 8'h00;
    end
    repeat (6) @(negedge clk);
    data_fifo_cnt = 12'd0;
    ptr_fifo_full = 1'b0;
  endtask

  task automatic drive_bytes(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      rx_dv = 1'b1; rx_d = b;
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pre, n, r, cnt, er;
    bit full;

    #3;
    check_eq("rst_data_wr", {31'd0, data_fifo_wr}, 32'd0);
    check_eq("rst_ptr_wr", {31'd0, ptr_fifo_wr}, 32'd0);
    check_eq("rst_data_din", {24'd0, data_fifo_din}, 32'd0);
    check_eq("rst_ptr_din", {16'd0, ptr_fifo_din}, 32'd0);
    check_eq("rst_frame_cnt", frame_cnt, 32'd0);
    check_eq("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check_eq("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(7, 100, -1, 0, 1'b0, 1'b1, 1'b0);
    compare_frame("f100");
    send_frame(7, 40, -1, 0, 1'b0, 1'b0, 1'b0);
    compare_frame("runt40");
    send_frame(7, 2000, -1, 0, 1'b0, 1'b0, 1'b0);
    compare_frame("giant2000");
    send_frame(7, 64, -1, 3000, 1'b0, 1'b0, 1'b0);
    compare_frame("nospace3000");
    send_frame(7, 64, 10, 0, 1'b0, 1'b0, 1'b0);
    compare_frame("rxer64");
    send_frame(7, 64, -1, 0, 1'b1, 1'b0, 1'b0);
    compare_frame("ptrfull");
    send_frame(3, 64, -1, 2578, 1'b0, 1'b0, 1'b0);
    compare_frame("space_edge_ok");
    send_frame(3, 64, -1, 2579, 1'b0, 1'b0, 1'b0);
    compare_frame("space_edge_drop");
    send_frame(0, 1518, -1, 0, 1'b0, 1'b0, 1'b0);
    compare_frame("exact_max");
    send_frame(0, 1519, -1, 0, 1'b0, 1'b0, 1'b0);
    compare_frame("max_plus1");
    send_frame(2, 63, -1, 0, 1'b0, 1'b0, 1'b0);
    compare_frame("min_minus1");
    send_frame(2, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    compare_frame("zero_len");
    send_frame(5, 70, -1, 0, 1'b0, 1'b0, 1'b1);
    compare_frame("commit_busy");

    // Garbage and aborted preambles never produce writes or count changes.
    @(negedge clk);
    drive_bytes(8'h12, 1);
    drive_bytes(8'hD5, 2);
    drive_bytes(8'h55, 2);
    rx_dv = 1'b0;
    repeat (2) @(negedge clk);
    drive_bytes(8'h55, 3);
    rx_dv = 1'b0;
    repeat (2) @(negedge clk);
    drive_bytes(8'h55, 2);
    drive_bytes(8'h33, 1);
    drive_bytes(8'hD5, 3);
    rx_dv = 1'b0;
    repeat (4) @(negedge clk);
    compare_frame("garbage");

    for (int k = 0; k < 40; k++) begin
      pre = $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      n = (r == 0) ? 0 : (r <= 6) ? $urandom_range(1, 100) : $urandom_range(1400, 1700);
      cnt = ($urandom_range(0, 9) < 2) ? $urandom_range(2579, 4095) : $urandom_range(0, 2578);
      full = ($urandom_range(0, 7) == 0);
      er = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (n > 0) ? n - 1 : 0) : -1;
      send_frame(pre, n, er, cnt, full, 1'b0, ($urandom_range(0, 9) == 0));
      compare_frame("rand");
    end

    // Reset in the middle of a frame discards it and clears all statistics.
    @(negedge clk);
    drive_bytes(8'h55, 2);
    drive_bytes(8'hD5, 1);
    drive_bytes(8'h3C, 20);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("midrst_data_wr", {31'd0, data_fifo_wr}, 32'd0);
    check_eq("midrst_ptr_wr", {31'd0, ptr_fifo_wr}, 32'd0);
    check_eq("midrst_data_din", {24'd0, data_fifo_din}, 32'd0);
    check_eq("midrst_frame_cnt", frame_cnt, 32'd0);
    got_d.delete();
    got_p.delete();
    exp_frame = 0;
    exp_drop = 0;
    exp_err = 0;
    @(negedge clk);
    rstn = 1'b1;
    drive_bytes(8'h3C, 5);
    rx_dv = 1'b0;
    repeat (6) @(negedge clk);
    compare_frame("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/port_rx_frontend.md
PORT_RX_FRONTEND -- requirements
Module: port_rx_frontend

Interface
REQ-001 SHALL have parameter MAX_LEN, 1518, largest accepted frame in bytes (max 2047).
REQ-002 SHALL have parameter MIN_LEN, 64, smallest non-runt frame in bytes.
REQ-003 SHALL have parameter FIFO_DEPTH, 4096, capacity of the downstream data FIFO in bytes.
REQ-004 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port: rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: rx_dv  in  1  receive data valid from MAC, one byte per cycle.
REQ-007 SHALL have port: rx_er  in  1  receive error, qualified by rx_dv.
REQ-008 SHALL have port: rx_d  in  8  receive byte, preamble and SFD included.
REQ-009 SHALL have port: data_fifo_wr  out  1  write strobe to port data FIFO.
REQ-010 SHALL have port: data_fifo_din  out  8  frame byte.
REQ-011 SHALL have port: data_fifo_cnt  in  12  current data FIFO occupancy.
REQ-012 SHALL have port: ptr_fifo_wr  out  1  write strobe to port pointer FIFO.
REQ-013 SHALL have port: ptr_fifo_din  out  16  frame descriptor.
REQ-014 SHALL have port: ptr_fifo_full  in  1  pointer FIFO full.
REQ-015 SHALL have ports: frame_cnt  out  32; drop_cnt  out  16; err_cnt  out  16  statistics.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE, DATA, COMMIT, DROP.
REQ-017 IDLE: rx_dv=1 with rx_d=0x55 -> PREAMBLE; rx_dv=1 with rx_d=0xD5 -> admission check; rx_dv=1 with other byte -> DROP; byte never written.
REQ-018 PREAMBLE: 0x55 stays; 0xD5 -> admission check; other byte -> DROP; rx_dv=0 -> IDLE, no counter change.
REQ-019 Admission (evaluated on the SFD cycle): accept when (FIFO_DEPTH - data_fifo_cnt) >= MAX_LEN and ptr_fifo_full=0 -> DATA, len=0, flags cleared; otherwise -> DROP with drop_cnt+1.
REQ-020 DATA: each cycle rx_dv=1 and len<MAX_LEN -> write rx_d, len+1; write registered, data_fifo_wr/din asserted the cycle after the byte is sampled.
REQ-021 DATA: byte arriving with len=MAX_LEN not written; sets length-error flag.
REQ-022 DATA: rx_er=1 with rx_dv=1 sets rx-error flag; byte still written.
REQ-023 DATA: first sample of rx_dv=0 -> COMMIT; set length-error flag if len<MIN_LEN.
REQ-024 COMMIT: ptr_fifo_wr=1 for exactly one cycle, ptr_fifo_din = {rx_err, len_err, 3'b000, len[10:0]}; ptr write strictly after the last data write.
REQ-025 COMMIT: frame_cnt+1 (wraps); err_cnt+1 when either flag set; next state IDLE, or DROP with drop_cnt+1 if rx_dv=1 in COMMIT.
REQ-026 DROP: no FIFO writes; stay until rx_dv=0, then IDLE.
REQ-027 Descriptor len SHALL always equal the number of bytes written for that frame (never 0, since SFD path requires >=1 byte before COMMIT; a zero-byte frame SHALL go to IDLE without ptr write or counters).
REQ-028 drop_cnt and err_cnt SHALL saturate at 0xFFFF.
REQ-029 data_fifo_wr and ptr_fifo_wr SHALL never be asserted in the same cycle as each other for different frames; at most one frame in flight.

Reset
REQ-030 rstn=0 SHALL asynchronously force IDLE, all strobes 0, data_fifo_din=0, ptr_fifo_din=0, all counters 0.
REQ-031 Reset mid-frame SHALL discard the frame with no ptr write; after release, bytes until rx_dv=0 are handled per REQ-017 (non-0x55/0xD5 -> DROP).

Verification
REQ-032 7x0x55, 0xD5, 100 bytes 0x00..0x63, rx_dv low -> 100 data writes in order, one ptr write 0x0064, frame_cnt=1.
REQ-033 Preamble + SFD + 40 bytes -> 40 data writes, ptr 0x4028, err_cnt=1.
REQ-034 Preamble + SFD + 2000 bytes -> 1518 writes, ptr 0x45EE, err_cnt=1.
REQ-035 data_fifo_cnt=3000 at SFD, 64-byte frame -> no writes, drop_cnt=1, frame_cnt=0.
REQ-036 64-byte frame with rx_er on byte 10 -> 64 writes, ptr 0x8040; ptr_fifo_full=1 at SFD -> frame dropped, drop_cnt+1.
